// File: rtl/uart_frame_pkg.sv
// ----------------------------------------------------------------------------
// uart_frame_pkg
// Shared definitions for the framed UART transmitter:
//   - tx_state_t   : serializer FSM states
//   - FRAME_BYTES  : bytes per frame (2 headers + 8 data + 1 checksum)
//   - HEAD*_DEF    : default header bytes
//   - calc_bps_cnt : clock cycles per bit (truncating division)
//   - frame_chk    : checksum of the 8 data bytes of a packed word
// ----------------------------------------------------------------------------
package uart_frame_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int         FRAME_BYTES = 11;
    localparam logic [7:0] HEAD0_DEF   = 8'hAA;
    localparam logic [7:0] HEAD1_DEF   = 8'h55;

    function automatic int calc_bps_cnt(input int clk_fs, input int uart_bps);
        return clk_fs / uart_bps;
    endfunction

    // Sum of the eight data bytes, modulo 256. Headers are not included.
    function automatic logic [7:0] frame_chk(input logic [63:0] word);
        logic [7:0] sum;
        sum = 8'd0;
        for (int i = 0; i < 8; i++) begin
            sum = sum + word[8*i +: 8];
        end
        return sum;
    endfunction

endpackage : uart_frame_pkg

// File: rtl/uart_frame_tx_byte.sv
// ----------------------------------------------------------------------------
// uart_byte_tx
// One-byte 8N1 serializer. Owns the START/DATA/STOP bit timing; each bit
// lasts BPS_CNT clock cycles. txd is registered, so the line follows the FSM
// state with one cycle of latency.
// Asserting tx_start during the last STOP cycle chains straight into the next
// start bit with no idle gap.
//
// Ports:
//   sys_clk   in   system clock
//   sys_rst_n in   asynchronous active-low reset
//   tx_start  in   begin a byte (sampled in IDLE and in the last STOP cycle)
//   tx_byte   in   byte to send; must be stable while in DATA
//   txd       out  serial line, idle high
//   tx_done   out  high during the last STOP cycle
// ----------------------------------------------------------------------------
module uart_byte_tx
    import uart_frame_pkg::*;
#(
    parameter int BPS_CNT = 434
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_byte,
    output logic       txd,
    output logic       tx_done
);

    localparam int              CNT_W    = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);

    tx_state_t        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic             txd_next;
    logic             cnt_last;

    assign cnt_last = (cnt == CNT_LAST);

    // Kept outside the FSM process so tx_done never depends on tx_start,
    // which the parent derives from tx_done.
    assign tx_done = (state == STOP) && cnt_last;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            txd     <= 1'b1;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
            txd     <= txd_next;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt + CNT_W'(1);
        bit_idx_next = bit_idx;
        txd_next     = 1'b1;

        case (state)
            IDLE: begin
                cnt_next = '0;
                if (tx_start) begin
                    state_next   = START;
                    bit_idx_next = '0;
                end
            end
            START: begin
                txd_next = 1'b0;
                if (cnt_last) begin
                    cnt_next     = '0;
                    state_next   = DATA;
                    bit_idx_next = '0;
                end
            end
            DATA: begin
                txd_next = tx_byte[bit_idx];
                if (cnt_last) begin
                    cnt_next = '0;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cnt_last) begin
                    cnt_next   = '0;
                    state_next = tx_start ? START : IDLE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

endmodule : uart_byte_tx

// File: rtl/uart_frame_tx.sv
// ----------------------------------------------------------------------------
// uart_frame_tx
// Frames a packed 64-bit frequency word as
//   HEAD0, HEAD1, data[63:56] ... data[7:0], CHK
// and sends it as 11 back-to-back 8N1 bytes. The word is latched on
// acceptance; strobes arriving while a frame is in flight are dropped and
// counted.
//
// Ports:
//   sys_clk    in   system clock
//   sys_rst_n  in   asynchronous active-low reset (aborts any frame)
//   uart_data  in   [63:32] channel 1 count, [31:0] channel 2 count
//   uart_en    in   one-cycle strobe qualifying uart_data
//   uart_txd   out  serial line, idle high
//   tx_busy    out  high from acceptance until the edge that returns to idle
//   frame_drop out  one-cycle pulse per strobe received while busy
//   drop_cnt   out  saturating count of dropped strobes
// ----------------------------------------------------------------------------
module uart_frame_tx
    import uart_frame_pkg::*;
#(
    parameter int         CLK_FS   = 50_000_000,
    parameter int         UART_BPS = 115200,
    parameter logic [7:0] HEAD0    = HEAD0_DEF,
    parameter logic [7:0] HEAD1    = HEAD1_DEF
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [63:0] uart_data,
    input  logic        uart_en,
    output logic        uart_txd,
    output logic        tx_busy,
    output logic        frame_drop,
    output logic [7:0]  drop_cnt
);

    localparam int         BPS_CNT   = calc_bps_cnt(CLK_FS, UART_BPS);
    localparam logic [3:0] LAST_BYTE = 4'(FRAME_BYTES - 1);

    logic [63:0] data_q;
    logic [3:0]  byte_idx;
    logic [7:0]  cur_byte;
    logic        accept;
    logic        tx_start;
    logic        tx_done;

    // The serializer is idle exactly when tx_busy is low, so busy doubles as
    // the "FSM not in IDLE" qualifier for acceptance and drops.
    assign accept   = uart_en && !tx_busy;
    assign tx_start = accept || (tx_done && (byte_idx != LAST_BYTE));

    // NOTE: the data latch is an ordinary register and is reset with the rest
    // of the state, so a post-reset frame never exposes stale data.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            data_q   <= '0;
            byte_idx <= '0;
            tx_busy  <= 1'b0;
        end else if (accept) begin
            data_q   <= uart_data;
            byte_idx <= '0;
            tx_busy  <= 1'b1;
        end else if (tx_done) begin
            if (byte_idx == LAST_BYTE) begin
                byte_idx <= '0;
                tx_busy  <= 1'b0;
            end else begin
                byte_idx <= byte_idx + 4'd1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            frame_drop <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            frame_drop <= uart_en && tx_busy;
            if (uart_en && tx_busy && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // Byte sequencer: data bytes go out MSB byte first; CHK comes from the
    // latched word so input changes mid-frame cannot affect it.
    always_comb begin
        cur_byte = 8'h00;
        case (byte_idx)
            4'd0:    cur_byte = HEAD0;
            4'd1:    cur_byte = HEAD1;
            4'd2:    cur_byte = data_q[63:56];
            4'd3:    cur_byte = data_q[55:48];
            4'd4:    cur_byte = data_q[47:40];
            4'd5:    cur_byte = data_q[39:32];
            4'd6:    cur_byte = data_q[31:24];
            4'd7:    cur_byte = data_q[23:16];
            4'd8:    cur_byte = data_q[15:8];
            4'd9:    cur_byte = data_q[7:0];
            4'd10:   cur_byte = frame_chk(data_q);
            default: cur_byte = 8'h00;
        endcase
    end

    uart_byte_tx #(
        .BPS_CNT (BPS_CNT)
    ) u_byte_tx (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .tx_start  (tx_start),
        .tx_byte   (cur_byte),
        .txd       (uart_txd),
        .tx_done   (tx_done)
    );

endmodule : uart_frame_tx

// File: tb/tb_uart_frame_tx.sv
// ----------------------------------------------------------------------------
// tb_uart_frame_tx
// Directed bench for uart_frame_tx at CLK_FS=1000, UART_BPS=100 (10 cycles
// per bit, 1100 cycles per frame). Inputs change and outputs are sampled 1
// time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_uart_frame_tx;

    localparam int CLK_FS    = 1000;
    localparam int UART_BPS  = 100;
    localparam int BIT_CYC   = 10;
    localparam int FRAME_CYC = 1100;

    typedef logic [7:0] frame_t [11];

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [63:0] uart_data = '0;
    logic        uart_en   = 1'b0;
    logic        uart_txd;
    logic        tx_busy;
    logic        frame_drop;
    logic [7:0]  drop_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 sys_clk = ~sys_clk;

    uart_frame_tx #(
        .CLK_FS   (CLK_FS),
        .UART_BPS (UART_BPS),
        .HEAD0    (8'hAA),
        .HEAD1    (8'h55)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .uart_data  (uart_data),
        .uart_en    (uart_en),
        .uart_txd   (uart_txd),
        .tx_busy    (tx_busy),
        .frame_drop (frame_drop),
        .drop_cnt   (drop_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Presents one strobe; returns 1 unit after the edge that samples it.
    task automatic send(input logic [63:0] data);
        uart_data = data;
        uart_en   = 1'b1;
        tick();
        uart_en   = 1'b0;
    endtask

    // Follows a frame cycle by cycle from the accepting edge (n=0) to the
    // edge where busy must have fallen (n=1100). Optional extra strobes are
    // injected so they are sampled at the edge ending cycle d1 / d2, and
    // uart_data is scrambled throughout to prove the word was latched.
    task automatic watch_frame(input frame_t exp, input string tag,
                               input int d1, input int d2, output int drops);
        logic [7:0] rx [11];
        int line_err;
        int busy_err;
        line_err = 0;
        busy_err = 0;
        drops    = 0;
        for (int i = 0; i < 11; i++) rx[i] = 8'h00;

        for (int n = 0; n < FRAME_CYC; n++) begin
            int   pos, b, k;
            logic exp_bit;
            exp_bit = 1'b1;
            if (n > 0) begin
                pos = (n - 1) / BIT_CYC;
                b   = pos / 10;
                k   = pos % 10;
                if (k == 0)      exp_bit = 1'b0;
                else if (k == 9) exp_bit = 1'b1;
                else             exp_bit = exp[b][k-1];
                if (((n - 1) % BIT_CYC) == 5 && k >= 1 && k <= 8)
                    rx[b][k-1] = uart_txd;
            end
            if (uart_txd !== exp_bit) line_err++;
            if (tx_busy !== 1'b1)     busy_err++;
            if (frame_drop === 1'b1)  drops++;
            uart_en   = (n == d1) || (n == d2);
            uart_data = {$urandom, $urandom};
            tick();
        end
        uart_en = 1'b0;
        if (frame_drop === 1'b1) drops++;

        check({tag, "_bit_timing_errs"}, 64'(line_err), 64'd0);
        check({tag, "_busy_low_cycles"}, 64'(busy_err), 64'd0);
        check({tag, "_busy_after_frame"}, 64'(tx_busy), 64'd0);
        check({tag, "_txd_after_frame"}, 64'(uart_txd), 64'd1);
        for (int i = 0; i < 11; i++)
            check($sformatf("%s_byte%0d", tag, i), 64'(rx[i]), 64'(exp[i]));
    endtask

    // Global bound: the directed sequence needs roughly 10k cycles.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        frame_t f_basic, f_ff, f_col, f_seq;
        int drops;
        int nonidle;
        int waited;

        f_basic = '{8'hAA, 8'h55, 8'h00, 8'h00, 8'h12, 8'h34, 8'h00, 8'h00, 8'h56, 8'h78, 8'h14};
        f_ff    = '{8'hAA, 8'h55, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF8};
        f_col   = '{8'hAA, 8'h55, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67, 8'h08};
        f_seq   = '{8'hAA, 8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h24};

        // Reset defaults
        repeat (5) tick();
        check("rst_txd_during", 64'(uart_txd), 64'd1);
        sys_rst_n = 1'b1;
        tick();
        check("rst_txd", 64'(uart_txd), 64'd1);
        check("rst_busy", 64'(tx_busy), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        check("rst_frame_drop", 64'(frame_drop), 64'd0);
        nonidle = 0;
        repeat (50) begin
            if (uart_txd !== 1'b1 || tx_busy !== 1'b0) nonidle++;
            tick();
        end
        check("rst_idle_line", 64'(nonidle), 64'd0);

        // Basic frame
        send(64'h0000_1234_0000_5678);
        check("basic_busy_at_accept", 64'(tx_busy), 64'd1);
        watch_frame(f_basic, "basic", -1, -1, drops);
        check("basic_drops", 64'(drops), 64'd0);
        repeat (5) tick();

        // Checksum wrap
        send(64'hFFFF_FFFF_FFFF_FFFF);
        watch_frame(f_ff, "wrap", -1, -1, drops);
        repeat (5) tick();

        // Collisions at cycle 300 and in the final STOP cycle
        send(64'hDEAD_BEEF_0123_4567);
        watch_frame(f_col, "collision", 300, FRAME_CYC - 1, drops);
        check("collision_drop_pulses", 64'(drops), 64'd2);
        check("collision_drop_cnt", 64'(drop_cnt), 64'd2);

        // Strobe one cycle after busy falls is accepted
        send(64'h0000_1234_0000_5678);
        check("reaccept_busy", 64'(tx_busy), 64'd1);
        check("reaccept_no_drop", 64'(frame_drop), 64'd0);
        watch_frame(f_basic, "reaccept", -1, -1, drops);
        check("reaccept_drop_cnt", 64'(drop_cnt), 64'd2);
        repeat (5) tick();

        // Saturation: 300 strobes while busy
        send(64'hFFFF_FFFF_FFFF_FFFF);
        uart_en = 1'b1;
        repeat (300) tick();
        uart_en = 1'b0;
        tick();
        check("sat_drop_cnt", 64'(drop_cnt), 64'd255);
        check("sat_still_busy", 64'(tx_busy), 64'd1);
        uart_en = 1'b1;
        repeat (5) tick();
        uart_en = 1'b0;
        tick();
        check("sat_drop_cnt_hold", 64'(drop_cnt), 64'd255);
        waited = 0;
        while (tx_busy === 1'b1 && waited < 2000) begin
            tick();
            waited++;
        end
        check("sat_frame_end", 64'(tx_busy), 64'd0);
        repeat (5) tick();

        // Reset mid-frame, during the start bit of frame byte 4
        send(64'h0000_1234_0000_5678);
        repeat (404) tick();
        check("midrst_line_low", 64'(uart_txd), 64'd0);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("midrst_txd", 64'(uart_txd), 64'd1);
        check("midrst_busy", 64'(tx_busy), 64'd0);
        check("midrst_drop_cnt", 64'(drop_cnt), 64'd0);
        repeat (3) tick();
        sys_rst_n = 1'b1;
        nonidle = 0;
        repeat (200) begin
            if (uart_txd !== 1'b1 || tx_busy !== 1'b0) nonidle++;
            tick();
        end
        check("midrst_stays_idle", 64'(nonidle), 64'd0);
        send(64'h0102_0304_0506_0708);
        watch_frame(f_seq, "postrst", -1, -1, drops);
        check("postrst_drops", 64'(drops), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_uart_frame_tx

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
- Consumes the packed 64-bit frequency word (two 32-bit channel counts) and its periodic one-cycle strobe from the frequency-to-UART packer.
- Frames the word as 11 bytes and serializes it on a UART TX pin (8N1, LSB-first per byte).
- Sits between the packer and the board TX pin. It is the transmitting end of the uart_data/uart_en interface.

Parameters:
- CLK_FS, 50_000_000, system clock frequency in Hz.
- UART_BPS, 115200, baud rate. Bit period BPS_CNT = CLK_FS/UART_BPS, integer-truncated (434 at defaults).
- HEAD0, 8'hAA, first frame header byte.
- HEAD1, 8'h55, second frame header byte.

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- sys_rst_n  input  1  asynchronous, active-low reset.
- uart_data  input  64  packed word: [63:32] channel 1, [31:0] channel 2.
- uart_en  input  1  one-cycle strobe; uart_data is valid in the same cycle.
- uart_txd  output  1  serial line, idle high.
- tx_busy  output  1  high while a frame is latched or being sent.
- frame_drop  output  1  one-cycle pulse when uart_en arrives while busy.
- drop_cnt  output  8  saturating count of dropped strobes.

Behaviour:
- Reset values (asynchronous, immediate): uart_txd=1, tx_busy=0, frame_drop=0, drop_cnt=0, FSM=IDLE, all counters 0, data latch 0.
- Frame byte order: HEAD0, HEAD1, uart_data[63:56] down to uart_data[7:0] (MSB byte first), then CHK.
  - CHK = sum of the 8 data bytes mod 256. Headers are excluded from CHK.
- Each byte on the line: start bit 0, 8 data bits LSB first, stop bit 1. Every bit lasts exactly BPS_CNT cycles.
- No idle gap between bytes: a stop bit is followed directly by the next start bit.
- Frame length: 11 x 10 x BPS_CNT cycles.
- Acceptance and latency:
  - uart_en sampled high while FSM=IDLE: latch uart_data and set tx_busy at that edge.
  - uart_txd goes low at the following edge (1-cycle latency).
- FSM states:
  - IDLE: txd=1. On uart_en go to START with byte index 0.
  - START: txd=0 for BPS_CNT cycles, then DATA with bit index 0.
  - DATA: txd = current byte[bit index]. Advance every BPS_CNT cycles; after bit 7 go to STOP.
  - STOP: txd=1 for BPS_CNT cycles. If byte index < 10, increment it and go to START; otherwise go to IDLE.
  - tx_busy falls on the same edge that enters IDLE.
- Busy collision:
  - uart_en in any non-IDLE cycle, including the last STOP cycle, is ignored.
  - frame_drop pulses for 1 cycle.
  - drop_cnt increments, saturating at 255.
  - The latched word is never overwritten mid-frame.
- The checksum is computed from the latched word, so changes on uart_data during a frame have no effect.
- Reset asserted mid-frame aborts the frame: uart_txd returns to 1 immediately and nothing resumes after release.
- Strobe periodicity: at 10 Hz strobes and defaults, a frame (47,740 cycles) is far shorter than the strobe period (5,000,000 cycles), so no drops occur in normal use.

Decomposition:
- Package uart_frame_pkg holds:
  - FSM state enum (IDLE, START, DATA, STOP).
  - FRAME_BYTES=11 and header defaults.
  - A function computing BPS_CNT from CLK_FS/UART_BPS.
- One sub-module is natural: uart_byte_tx.
  - Inputs: tx_start, tx_byte. Outputs: txd, tx_done (pulses in the last STOP cycle).
  - It owns the START/DATA/STOP bit timing.
- uart_frame_tx keeps the byte sequencer (index, byte mux, checksum), the acceptance logic and the drop counter.

Test Plan:
- Run all scenarios with CLK_FS=1000 and UART_BPS=100 (BPS_CNT=10).
- Reset defaults: hold sys_rst_n low for 5 cycles, then release -> uart_txd=1, tx_busy=0, drop_cnt=0, and the line stays high with no strobe.
- Basic frame: uart_en with uart_data=64'h0000_1234_0000_5678.
  - Line decodes to AA 55 00 00 12 34 00 00 56 78 14.
  - First falling edge is 1 cycle after the strobe, and every bit is exactly 10 cycles.
  - tx_busy stays high for 1100 cycles.
- Checksum wrap: uart_data=64'hFFFF_FFFF_FFFF_FFFF -> data bytes are all FF and CHK=F8.
- Collision: second uart_en at cycle 300 of a frame, and another in the final STOP cycle.
  - Two frame_drop pulses; drop_cnt=2.
  - The frame completes unaltered.
  - A strobe 1 cycle after tx_busy falls is accepted.
- Saturation: 300 strobes while busy -> drop_cnt=255 and holds.
- Reset mid-frame: assert sys_rst_n low during data byte 3 -> uart_txd=1 immediately and stays idle after release. A new strobe then produces a complete, correct frame.
